// File: rtl/dsp_pkg.sv
// dsp_pkg
// Shared definitions for the DSP gain blocks: bus register addresses, the
// multiplier mode encoding and a generic saturating clamp helper.
// No ports (package).
package dsp_pkg;

  // Bus register map
  localparam logic [15:0] ADDR_CTRL      = 16'h0100;
  localparam logic [15:0] ADDR_GAIN      = 16'h0104;
  localparam logic [15:0] ADDR_SHIFT     = 16'h0108;
  localparam logic [15:0] ADDR_OFFSET    = 16'h010C;
  localparam logic [15:0] ADDR_STATUS    = 16'h0110;
  localparam logic [15:0] ADDR_SAT_COUNT = 16'h0114;

  // Operand selection for the multiplier
  typedef enum logic [1:0] {
    MODE_AB     = 2'd0,
    MODE_AGAIN  = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_BYPASS = 2'd3
  } mode_t;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] value;
  } sat_result_t;

  // Clamp a wide signed value into the range of a signed 'bits'-wide number.
  // The sat flag reports whether the clamp changed the value.
  function automatic sat_result_t sat_clamp(input logic signed [63:0] v,
                                            input int unsigned        bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_result_t        r;
    hi      = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (bits - 1));
    r.sat   = 1'b0;
    r.value = v;
    if (v > hi) begin
      r.sat   = 1'b1;
      r.value = hi;
    end else if (v < lo) begin
      r.sat   = 1'b1;
      r.value = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_shift_sat.sv
// mult_shift_sat
// Output stage of the gain blocks: arithmetic right shift of a full-precision
// product, signed offset add and clamp to OUT_BITS, all registered.
// Ports:
//   clk_i, rstn_i  clock, asynchronous active-low reset
//   sync_i         synchronous flush of the output register
//   en_i           stage enable; when low the output is forced to zero
//   prod_i         PW-bit signed product
//   shift_i        right shift amount (limited to PW-1)
//   offset_i       signed offset added after the shift
//   dat_o, sat_o   registered result and clamp indicator
module mult_shift_sat
  import dsp_pkg::*;
#(
  parameter int PW       = 30,
  parameter int OUT_BITS = 14
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       sync_i,
  input  logic                       en_i,
  input  logic signed [PW-1:0]       prod_i,
  input  logic [5:0]                 shift_i,
  input  logic signed [OUT_BITS-1:0] offset_i,
  output logic signed [OUT_BITS-1:0] dat_o,
  output logic                       sat_o
);

  logic [5:0]           shift_eff;
  logic signed [PW-1:0] shifted;
  logic signed [63:0]   sum;
  sat_result_t          clamp;

  // Shifting by PW-1 already leaves only the sign, so larger requests are
  // capped there. >>> on a signed value rounds toward -inf.
  always_comb begin
    shift_eff = (int'(shift_i) > PW - 1) ? 6'(PW - 1) : shift_i;
    shifted   = prod_i >>> shift_eff;
    sum       = 64'(shifted) + 64'(offset_i);
    clamp     = sat_clamp(sum, OUT_BITS);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dat_o <= '0;
      sat_o <= 1'b0;
    end else if (sync_i || !en_i) begin
      dat_o <= '0;
      sat_o <= 1'b0;
    end else begin
      dat_o <= clamp.value[OUT_BITS-1:0];
      sat_o <= clamp.sat;
    end
  end

endmodule

// File: rtl/red_pitaya_mult_gain_block.sv
// red_pitaya_mult_gain_block
// Pipelined signed multiplier with bus-programmable mode, gain, shift, offset
// and output saturation. Latency is 3 cycles from dat_i/dat2_i to dat_o.
// Optional feature macro: MULT_SAT_COUNTER_EN adds a 32-bit saturating
// SAT_COUNT register at 0x114 (reads 0 when the macro is undefined).
// Ports:
//   clk_i, rstn_i  clock, asynchronous active-low reset
//   sync_i         pipeline flush, active high
//   dat_i, dat2_i  signed operands A and B
//   dat_o, sat_o   registered result and clamp indicator
//   addr, wen, ren, wdata, ack, rdata  register bus
module red_pitaya_mult_gain_block
  import dsp_pkg::*;
#(
  parameter int IN1_BITS  = 14,
  parameter int IN2_BITS  = 14,
  parameter int GAIN_BITS = 16,
  parameter int OUT_BITS  = 14
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       sync_i,
  input  logic signed [IN1_BITS-1:0] dat_i,
  input  logic signed [IN2_BITS-1:0] dat2_i,
  output logic signed [OUT_BITS-1:0] dat_o,
  output logic                       sat_o,
  input  logic [15:0]                addr,
  input  logic                       wen,
  input  logic                       ren,
  output logic                       ack,
  output logic [31:0]                rdata,
  input  logic [31:0]                wdata
);

  localparam int OP2_BITS = (IN2_BITS > GAIN_BITS) ? IN2_BITS : GAIN_BITS;
  localparam int PW       = IN1_BITS + OP2_BITS;

  // Configuration registers
  mode_t                       cfg_mode;
  logic                        cfg_en;
  logic signed [GAIN_BITS-1:0] cfg_gain;
  logic [5:0]                  cfg_shift;
  logic signed [OUT_BITS-1:0]  cfg_offset;
  logic                        sat_sticky;

  // S1: operands plus the configuration they must be processed with
  logic signed [IN1_BITS-1:0]  s1_a;
  logic signed [IN2_BITS-1:0]  s1_b;
  logic signed [GAIN_BITS-1:0] s1_gain;
  mode_t                       s1_mode;
  logic                        s1_en;
  logic [5:0]                  s1_shift;
  logic signed [OUT_BITS-1:0]  s1_offset;

  // S2: full-precision product
  logic signed [PW-1:0]        s2_prod;
  logic                        s2_en;
  logic [5:0]                  s2_shift;
  logic signed [OUT_BITS-1:0]  s2_offset;

  logic signed [PW-1:0]        a_ext;
  logic signed [PW-1:0]        op2;
  logic signed [PW-1:0]        prod_next;
  logic [31:0]                 read_val;
  logic                        status_w1c;
  logic                        unused_ok;

  assign status_w1c = wen && (addr == ADDR_STATUS) && wdata[0];
  assign unused_ok  = &{1'b0, wdata};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cfg_mode   <= MODE_AB;
      cfg_en     <= 1'b0;
      cfg_gain   <= '0;
      cfg_shift  <= '0;
      cfg_offset <= '0;
    end else if (wen) begin
      case (addr)
        ADDR_CTRL: begin
          cfg_mode <= mode_t'(wdata[1:0]);
          cfg_en   <= wdata[2];
        end
        ADDR_GAIN:   cfg_gain   <= wdata[GAIN_BITS-1:0];
        ADDR_SHIFT:  cfg_shift  <= wdata[5:0];
        ADDR_OFFSET: cfg_offset <= wdata[OUT_BITS-1:0];
        default: ;
      endcase
    end
  end

  // New saturation wins over a simultaneous write-1-to-clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sat_sticky <= 1'b0;
    end else begin
      sat_sticky <= (sat_sticky && !status_w1c) || sat_o;
    end
  end

`ifdef MULT_SAT_COUNTER_EN
  logic [31:0] sat_count;

  // Clear has priority over a coincident increment; the count sticks at max.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sat_count <= '0;
    end else if (wen && (addr == ADDR_SAT_COUNT)) begin
      sat_count <= '0;
    end else if (sat_o && (sat_count != 32'hFFFF_FFFF)) begin
      sat_count <= sat_count + 32'd1;
    end
  end
`endif

  always_comb begin
    read_val = '0;
    case (addr)
      ADDR_CTRL:   read_val = {29'd0, cfg_en, cfg_mode};
      ADDR_GAIN:   read_val = 32'(cfg_gain);
      ADDR_SHIFT:  read_val = {26'd0, cfg_shift};
      ADDR_OFFSET: read_val = 32'(cfg_offset);
      ADDR_STATUS: read_val = {31'd0, sat_sticky};
`ifdef MULT_SAT_COUNTER_EN
      ADDR_SAT_COUNT: read_val = sat_count;
`endif
      default:     read_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= wen || ren;
      if (ren) begin
        rdata <= read_val;
      end
    end
  end

  // Capture the config alongside the data so that a register write lands
  // cleanly between two samples.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_a      <= '0;
      s1_b      <= '0;
      s1_gain   <= '0;
      s1_mode   <= MODE_AB;
      s1_en     <= 1'b0;
      s1_shift  <= '0;
      s1_offset <= '0;
    end else if (sync_i) begin
      s1_a      <= '0;
      s1_b      <= '0;
      s1_gain   <= '0;
      s1_mode   <= MODE_AB;
      s1_en     <= 1'b0;
      s1_shift  <= '0;
      s1_offset <= '0;
    end else begin
      s1_a      <= dat_i;
      s1_b      <= dat2_i;
      s1_gain   <= cfg_gain;
      s1_mode   <= cfg_mode;
      s1_en     <= cfg_en;
      s1_shift  <= cfg_shift;
      s1_offset <= cfg_offset;
    end
  end

  // Both factors are sign-extended to PW, so the PW-bit product is exact.
  always_comb begin
    a_ext = PW'(s1_a);
    op2   = '0;
    case (s1_mode)
      MODE_AB:     op2 = PW'(s1_b);
      MODE_AGAIN:  op2 = PW'(s1_gain);
      MODE_SQUARE: op2 = a_ext;
      default:     op2 = '0;
    endcase
    prod_next = (s1_mode == MODE_BYPASS) ? a_ext : a_ext * op2;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s2_prod   <= '0;
      s2_en     <= 1'b0;
      s2_shift  <= '0;
      s2_offset <= '0;
    end else if (sync_i) begin
      s2_prod   <= '0;
      s2_en     <= 1'b0;
      s2_shift  <= '0;
      s2_offset <= '0;
    end else begin
      s2_prod   <= prod_next;
      s2_en     <= s1_en;
      s2_shift  <= s1_shift;
      s2_offset <= s1_offset;
    end
  end

  mult_shift_sat #(
    .PW       (PW),
    .OUT_BITS (OUT_BITS)
  ) u_shift_sat (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .sync_i   (sync_i),
    .en_i     (s2_en),
    .prod_i   (s2_prod),
    .shift_i  (s2_shift),
    .offset_i (s2_offset),
    .dat_o    (dat_o),
    .sat_o    (sat_o)
  );

endmodule

// File: tb/tb_red_pitaya_mult_gain_block.sv
// tb_red_pitaya_mult_gain_block
// Directed and random stimulus for red_pitaya_mult_gain_block, checked every
// cycle against an arithmetic reference model of the gain block.
// Honours MULT_SAT_COUNTER_EN in the same way as the design.
module tb_red_pitaya_mult_gain_block;

  localparam int PW = 30;

  logic               clk_i = 1'b0;
  logic               rstn_i;
  logic               sync_i;
  logic signed [13:0] dat_i;
  logic signed [13:0] dat2_i;
  logic signed [13:0] dat_o;
  logic               sat_o;
  logic [15:0]        addr;
  logic               wen;
  logic               ren;
  logic               ack;
  logic [31:0]        rdata;
  logic [31:0]        wdata;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_mode;
  bit          m_en;
  int          m_gain;
  int          m_shift;
  int          m_offset;
  bit          m_status;
  logic [31:0] m_cnt;
  longint      pipe_val[3];
  bit          pipe_sat[3];

  red_pitaya_mult_gain_block dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .sync_i (sync_i),
    .dat_i  (dat_i),
    .dat2_i (dat2_i),
    .dat_o  (dat_o),
    .sat_o  (sat_o),
    .addr   (addr),
    .wen    (wen),
    .ren    (ren),
    .ack    (ack),
    .rdata  (rdata),
    .wdata  (wdata)
  );

  always #5 clk_i = ~clk_i;

  function automatic void model_reset();
    m_mode   = 0;
    m_en     = 1'b0;
    m_gain   = 0;
    m_shift  = 0;
    m_offset = 0;
    m_status = 1'b0;
    m_cnt    = '0;
    for (int i = 0; i < 3; i++) begin
      pipe_val[i] = 0;
      pipe_sat[i] = 1'b0;
    end
  endfunction

  // Result for one sample under the current register settings: plain integer
  // product, floor division by 2^shift, offset, clamp to 14-bit signed.
  function automatic void model_sample(input longint a, input longint b,
                                       output longint val, output bit sat);
    longint p;
    longint d;
    longint v;
    int     sh;
    val = 0;
    sat = 1'b0;
    if (m_en) begin
      case (m_mode)
        0:       p = a * b;
        1:       p = a * longint'(m_gain);
        2:       p = a * a;
        default: p = a;
      endcase
      sh = (m_shift > PW - 1) ? PW - 1 : m_shift;
      d  = longint'(1) << sh;
      if (p >= 0) v = p / d;
      else        v = -((-p + d - 1) / d);
      v = v + longint'(m_offset);
      if (v > 8191)       begin val = 8191;  sat = 1'b1; end
      else if (v < -8192) begin val = -8192; sat = 1'b1; end
      else                val = v;
    end
  endfunction

  function automatic logic [31:0] reg_read(input logic [15:0] a);
    case (a)
      16'h0100: return {29'd0, m_en, 2'(m_mode)};
      16'h0104: return 32'(m_gain);
      16'h0108: return 32'(m_shift);
      16'h010C: return 32'(m_offset);
      16'h0110: return {31'd0, m_status};
`ifdef MULT_SAT_COUNTER_EN
      16'h0114: return m_cnt;
`endif
      default:  return 32'd0;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic signed [63:0] obs,
                              input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: predict from the inputs present at the edge, advance
  // the model, then compare every output just after the edge.
  task automatic tick();
    longint      nv;
    bit          ns;
    bit          prev_sat;
    bit          ack_exp;
    bit          rd_chk;
    logic [31:0] rd_exp;
    model_sample(longint'(dat_i), longint'(dat2_i), nv, ns);
    prev_sat = pipe_sat[2];
    ack_exp  = wen | ren;
    rd_chk   = ren;
    rd_exp   = reg_read(addr);
    @(posedge clk_i);
    if (!rstn_i) begin
      model_reset();
      ack_exp = 1'b0;
      rd_chk  = 1'b1;
      rd_exp  = '0;
    end else begin
      if (sync_i) begin
        for (int i = 0; i < 3; i++) begin
          pipe_val[i] = 0;
          pipe_sat[i] = 1'b0;
        end
      end else begin
        pipe_val[2] = pipe_val[1]; pipe_sat[2] = pipe_sat[1];
        pipe_val[1] = pipe_val[0]; pipe_sat[1] = pipe_sat[0];
        pipe_val[0] = nv;          pipe_sat[0] = ns;
      end
      if (wen && addr == 16'h0110 && wdata[0]) m_status = 1'b0;
      if (prev_sat) m_status = 1'b1;
      if (wen && addr == 16'h0114) m_cnt = '0;
      else if (prev_sat && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (wen) begin
        case (addr)
          16'h0100: begin m_mode = int'(wdata[1:0]); m_en = wdata[2]; end
          16'h0104: m_gain   = int'($signed(wdata[15:0]));
          16'h0108: m_shift  = int'(wdata[5:0]);
          16'h010C: m_offset = int'($signed(wdata[13:0]));
          default: ;
        endcase
      end
    end
    #1;
    check_output("dat_o", dat_o, pipe_val[2]);
    check_output("sat_o", sat_o, pipe_sat[2]);
    check_output("ack", ack, ack_exp);
    if (rd_chk) check_output("rdata", rdata, rd_exp);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wen   = 1'b1;
    tick();
    wen   = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a);
    addr = a;
    ren  = 1'b1;
    tick();
    ren  = 1'b0;
  endtask

  task automatic set_data(input int a, input int b);
    dat_i  = 14'(a);
    dat2_i = 14'(b);
  endtask

  initial begin
    rstn_i = 1'b0;
    sync_i = 1'b0;
    wen    = 1'b0;
    ren    = 1'b0;
    addr   = '0;
    wdata  = '0;
    set_data(0, 0);
    model_reset();
    #1;
    check_output("reset_dat_o", dat_o, 0);
    check_output("reset_sat_o", sat_o, 0);
    check_output("reset_ack", ack, 0);
    check_output("reset_rdata", rdata, 0);
    tick();
    tick();
    rstn_i = 1'b1;
    tick();

    // Mode 0, 4096*4096 >> 13
    bus_write(16'h0100, 32'd4);
    bus_write(16'h0108, 32'd13);
    set_data(4096, 4096);
    tick();
    set_data(0, 0);
    tick();
    tick();
    check_output("tp1_dat", dat_o, 2048);
    check_output("tp1_sat", sat_o, 0);

    // Positive overflow, sticky status and write-1-to-clear
    bus_write(16'h0108, 32'd0);
    set_data(-8192, -8192);
    tick();
    set_data(0, 0);
    tick();
    tick();
    check_output("tp2_dat", dat_o, 8191);
    check_output("tp2_sat", sat_o, 1);
    tick();
    check_output("tp2_sat_end", sat_o, 0);
    bus_read(16'h0110);
    check_output("tp2_status", rdata, 1);
    bus_write(16'h0110, 32'd1);
    bus_read(16'h0110);
    check_output("tp2_status_clr", rdata, 0);

    // Mode 1 with offset, then a mid-stream gain change
    bus_write(16'h0100, 32'd5);
    bus_write(16'h0104, 32'd16384);
    bus_write(16'h0108, 32'd14);
    bus_write(16'h010C, 32'hFFFF_FFCE);
    set_data(100, 0);
    tick();
    tick();
    tick();
    check_output("tp3_gain_pos", dat_o, 50);
    bus_write(16'h0104, 32'hFFFF_C000);
    tick();
    tick();
    check_output("tp3_old_gain", dat_o, 50);
    tick();
    check_output("tp3_new_gain", dat_o, -150);

    // Mode 2 streaming with a one-cycle sync pulse
    bus_write(16'h0100, 32'd6);
    bus_write(16'h0108, 32'd10);
    bus_write(16'h010C, 32'd0);
    set_data(1000, 0);
    tick();
    tick();
    tick();
    check_output("tp4_square", dat_o, 976);
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    check_output("tp4_flush0", dat_o, 0);
    tick();
    check_output("tp4_flush1", dat_o, 0);
    tick();
    check_output("tp4_flush2", dat_o, 0);
    tick();
    check_output("tp4_resume", dat_o, 976);

    // Unmapped address reads zero
    bus_read(16'h0100);
    bus_read(16'h01FC);
    check_output("unmapped_ack", ack, 1);
    check_output("unmapped_rdata", rdata, 0);

    // Saturation counter (or its absence)
    set_data(0, 0);
    bus_write(16'h0100, 32'd4);
    bus_write(16'h0108, 32'd0);
    tick();
    tick();
    tick();
    bus_write(16'h0114, 32'd0);
    set_data(-8192, -8192);
    for (int i = 0; i < 5; i++) tick();
    set_data(0, 0);
    for (int i = 0; i < 4; i++) tick();
    bus_read(16'h0114);
`ifdef MULT_SAT_COUNTER_EN
    check_output("sat_count_5", rdata, 5);
`else
    check_output("sat_count_absent", rdata, 0);
`endif
    bus_write(16'h0114, 32'd0);
    bus_read(16'h0114);
    check_output("sat_count_clr", rdata, 0);

    // Random traffic: data, config writes, reads and occasional syncs
    for (int i = 0; i < 400; i++) begin
      set_data(int'($urandom_range(0, 16383)) - 8192,
               int'($urandom_range(0, 16383)) - 8192);
      sync_i = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 9))
        0: begin
          wen   = 1'b1;
          addr  = 16'h0100 + 16'(4 * $urandom_range(0, 5));
          wdata = $urandom;
        end
        1: begin
          ren  = 1'b1;
          addr = ($urandom_range(0, 6) == 6) ? 16'h01FC
                                             : 16'h0100 + 16'(4 * $urandom_range(0, 5));
        end
        default: ;
      endcase
      tick();
      wen    = 1'b0;
      ren    = 1'b0;
      sync_i = 1'b0;
    end

    // Asynchronous reset in the middle of a stream
    bus_write(16'h0100, 32'd4);
    bus_write(16'h0108, 32'd13);
    bus_write(16'h010C, 32'd0);
    set_data(4096, 4096);
    tick();
    tick();
    tick();
    bus_read(16'h0100);
    check_output("pre_reset_dat", dat_o, 2048);
    #3;
    rstn_i = 1'b0;
    #1;
    model_reset();
    check_output("async_rst_dat", dat_o, 0);
    check_output("async_rst_sat", sat_o, 0);
    check_output("async_rst_ack", ack, 0);
    check_output("async_rst_rdata", rdata, 0);
    tick();
    rstn_i = 1'b1;
    bus_read(16'h0100);
    check_output("post_rst_ctrl", rdata, 0);
    bus_read(16'h0104);
    bus_read(16'h0108);
    bus_read(16'h010C);
    bus_read(16'h0110);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
